// File: rtl/img_buf_pkg.sv
// Shared constants and types for the image-buffer port arbiter.
package img_buf_pkg;

    localparam int ADDR_W       = 9;
    localparam int DATA_W       = 512;
    localparam int MAX_HOLD_DEF = 16;

    typedef enum logic {CLI_HOST = 1'b0, CLI_COP = 1'b1} client_t;

    typedef logic [ADDR_W-1:0] row_addr_t;

endpackage

// File: rtl/img_buf_rr_lock_arb.sv
// Two-way round-robin arbiter with a bounded lock; one instance per buffer port.
module img_buf_rr_lock_arb
    import img_buf_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    localparam int CW      = $clog2(MAX_HOLD + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    output logic [1:0] gnt
);

    client_t        owner_q;
    logic [CW-1:0]  cnt_q;
    logic           o;

    assign o = owner_q;

    // Grants are forced off during reset so nothing is issued in that cycle.
    always_comb begin
        gnt = '0;
        if (!rst) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11: begin
                    if (lock[o] && (cnt_q < CW'(MAX_HOLD)))
                        gnt[o]  = 1'b1;
                    else
                        gnt[~o] = 1'b1;
                end
                default: gnt = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= CLI_COP;
            cnt_q   <= '0;
        end else if (|gnt) begin
            if (gnt[o]) begin
                if (cnt_q != CW'(MAX_HOLD))
                    cnt_q <= cnt_q + 1'b1;
            end else begin
                owner_q <= client_t'(gnt[1]);
                cnt_q   <= CW'(1);
            end
        end else begin
            cnt_q <= '0;
        end
    end

endmodule

// File: rtl/img_buf_port_arb2.sv
// Host/coprocessor arbiter for one image-buffer bank; independent read and write ports.
module img_buf_port_arb2
    import img_buf_pkg::*;
#(
    parameter int ADDR_W   = img_buf_pkg::ADDR_W,
    parameter int DATA_W   = img_buf_pkg::DATA_W,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            rd_req,
    input  logic [1:0]            rd_lock,
    input  logic [2*ADDR_W-1:0]   rd_addr,
    output logic [1:0]            rd_gnt,
    output logic [1:0]            rd_valid,
    output logic [DATA_W-1:0]     rd_data,
    input  logic [1:0]            wr_req,
    input  logic [1:0]            wr_lock,
    input  logic [2*ADDR_W-1:0]   wr_addr,
    input  logic [2*DATA_W-1:0]   wr_data,
    output logic [1:0]            wr_gnt,
    output logic [ADDR_W-1:0]     buf_raddr,
    input  logic [DATA_W-1:0]     buf_rdata,
    output logic                  buf_we,
    output logic [ADDR_W-1:0]     buf_waddr,
    output logic [DATA_W-1:0]     buf_wdata
);

    img_buf_rr_lock_arb #(.MAX_HOLD(MAX_HOLD)) u_rd_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (rd_req),
        .lock (rd_lock),
        .gnt  (rd_gnt)
    );

    img_buf_rr_lock_arb #(.MAX_HOLD(MAX_HOLD)) u_wr_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (wr_req),
        .lock (wr_lock),
        .gnt  (wr_gnt)
    );

    // Without a grant the muxes fall back to the host's inputs.
    assign buf_raddr = rd_gnt[CLI_COP] ? rd_addr[2*ADDR_W-1:ADDR_W] : rd_addr[ADDR_W-1:0];
    assign buf_we    = |wr_gnt;
    assign buf_waddr = wr_gnt[CLI_COP] ? wr_addr[2*ADDR_W-1:ADDR_W] : wr_addr[ADDR_W-1:0];
    assign buf_wdata = wr_gnt[CLI_COP] ? wr_data[2*DATA_W-1:DATA_W] : wr_data[DATA_W-1:0];

    // The buffer read is registered, so data lines up with the delayed grant.
    assign rd_data = buf_rdata;

    always_ff @(posedge clk) begin
        if (rst)
            rd_valid <= '0;
        else
            rd_valid <= rd_gnt;
    end

endmodule
